// File: rtl/mem_req_arb_pkg.sv
// Shared types for the memory request arbiter: bus command, requester id,
// owner-table entry, arbiter FSM state and the fixed-priority pick helper.
package mem_req_arb_pkg;

  localparam int NUM_REQ = 3;

  typedef enum logic [1:0] {
    CMD_NONE  = 2'd0,
    CMD_LOAD  = 2'd1,
    CMD_STORE = 2'd2
  } mem_cmd_e;

  // Value doubles as the bit position in the per-requester request vectors.
  typedef enum logic [1:0] {
    ID_IC = 2'd0,
    ID_DL = 2'd1,
    ID_DS = 2'd2
  } req_id_e;

  typedef struct packed {
    logic    vld;
    req_id_e id;
  } owner_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } arb_state_e;

  // Fixed order ds > dl > ic over a request mask.
  function automatic req_id_e pick_id(input logic [NUM_REQ-1:0] m);
    req_id_e id;
    if (m[2])      id = ID_DS;
    else if (m[1]) id = ID_DL;
    else           id = ID_IC;
    return id;
  endfunction

endpackage

// File: rtl/mem_tag_owner_tbl.sv
// Memory-tag owner table plus outstanding-load counter. A return on the same
// tag as a new allocation frees the old entry first, so the allocation wins.
module mem_tag_owner_tbl
  import mem_req_arb_pkg::*;
#(
  parameter int TAG_W      = 4,
  parameter int MAX_LD_OUT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_i,
  input  logic [TAG_W-1:0] alloc_tag_i,
  input  req_id_e          alloc_id_i,
  input  logic [TAG_W-1:0] ret_tag_i,
  output logic             ret_hit_o,
  output req_id_e          ret_id_o,
  output logic             ld_full_o
);

  localparam int NTAG = 1 << TAG_W;
  localparam int CW   = $clog2(MAX_LD_OUT + 1);

  owner_t [NTAG-1:0] owner_q, owner_d;
  logic   [CW-1:0]   ld_cnt_q, ld_cnt_d;

  // Tag 0 never names an owner; lookup is combinational so rsp has no latency.
  always_comb begin
    ret_hit_o = (ret_tag_i != '0) && owner_q[ret_tag_i].vld;
    ret_id_o  = owner_q[ret_tag_i].id;
    ld_full_o = (ld_cnt_q >= CW'(MAX_LD_OUT));
  end

  // Free then allocate; count moves only when exactly one of the two happens.
  always_comb begin
    owner_d  = owner_q;
    ld_cnt_d = ld_cnt_q;
    if (ret_hit_o) owner_d[ret_tag_i] = '0;
    if (alloc_i)   owner_d[alloc_tag_i] = '{vld: 1'b1, id: alloc_id_i};
    if (alloc_i && !ret_hit_o && (ld_cnt_q != CW'(MAX_LD_OUT)))
      ld_cnt_d = ld_cnt_q + CW'(1);
    else if (!alloc_i && ret_hit_o && (ld_cnt_q != '0))
      ld_cnt_d = ld_cnt_q - CW'(1);
  end

  // Table and counter state; reset discards every outstanding load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q  <= '0;
      ld_cnt_q <= '0;
    end else begin
      owner_q  <= owner_d;
      ld_cnt_q <= ld_cnt_d;
    end
  end

endmodule

// File: rtl/mem_req_arb.sv
// Three-way main-memory arbiter (Icache load, Dcache load, Dcache store).
// Fixed priority ds > dl > ic; a losing-to-memory grant is held until accepted
// or withdrawn. Define MEM_REQ_ARB_FAIR_EN to add per-requester starvation
// counters that promote a requester after STARVE_LIMIT waiting cycles.
module mem_req_arb
  import mem_req_arb_pkg::*;
#(
  parameter int TAG_W        = 4,
  parameter int MAX_LD_OUT   = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ic_req_i,
  input  logic             dl_req_i,
  input  logic             ds_req_i,
  input  logic [63:0]      ic_addr_i,
  input  logic [63:0]      dl_addr_i,
  input  logic [63:0]      ds_addr_i,
  input  logic [63:0]      ds_data_i,
  output logic             ic_ack_o,
  output logic             dl_ack_o,
  output logic             ds_ack_o,
  output logic             ic_rsp_vld_o,
  output logic             dl_rsp_vld_o,
  output logic [TAG_W-1:0] rsp_tag_o,
  output logic [63:0]      rsp_data_o,
  output logic [1:0]       proc2mem_cmd_o,
  output logic [63:0]      proc2mem_addr_o,
  output logic [63:0]      proc2mem_data_o,
  input  logic [TAG_W-1:0] mem2proc_response_i,
  input  logic [TAG_W-1:0] mem2proc_tag_i,
  input  logic [63:0]      mem2proc_data_i,
  output logic             arb_ld_full_o
);

  arb_state_e         state_q, state_d;
  req_id_e            hold_id_q, hold_id_d;
  req_id_e            gnt_id, ret_id;
  mem_cmd_e           cmd;
  logic [NUM_REQ-1:0] req, elig, sel_mask, ack;
  logic               ld_full, ret_hit, gnt_vld, accept, hold_req, hold_live;

  // Requests are masked while in reset so every output sits at its idle value.
  always_comb begin
    req  = {ds_req_i, dl_req_i, ic_req_i} & {NUM_REQ{rst}};
    elig = req & {1'b1, ~ld_full, ~ld_full};
    case (hold_id_q)
      ID_DS:   hold_req = req[2];
      ID_DL:   hold_req = req[1];
      default: hold_req = req[0];
    endcase
    hold_live = (state_q == S_HOLD) && hold_req;
  end

`ifdef MEM_REQ_ARB_FAIR_EN
  localparam int WW = $clog2(STARVE_LIMIT + 1);

  logic [NUM_REQ-1:0][WW-1:0] wait_q, wait_d;
  logic [NUM_REQ-1:0]         promo;

  // Promoted requesters form their own tier; fixed order still breaks ties.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) promo[i] = (wait_q[i] >= WW'(STARVE_LIMIT));
    sel_mask = (|(elig & promo)) ? (elig & promo) : elig;
  end

  // Saturating wait count: grows while requesting unacked, clears on ack.
  always_comb begin
    wait_d = wait_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ack[i])                                    wait_d[i] = '0;
      else if (req[i] && (wait_q[i] < WW'(STARVE_LIMIT))) wait_d[i] = wait_q[i] + WW'(1);
    end
  end

  // Starvation counter state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wait_q <= '0;
    else      wait_q <= wait_d;
  end
`else
  assign sel_mask = elig;
`endif

  // Grant selection and IDLE/HOLD next state; a withdrawn hold re-arbitrates now.
  always_comb begin
    state_d   = state_q;
    hold_id_d = hold_id_q;
    gnt_vld   = 1'b0;
    gnt_id    = ID_IC;
    if (hold_live) begin
      gnt_vld = 1'b1;
      gnt_id  = hold_id_q;
    end else if (|sel_mask) begin
      gnt_vld = 1'b1;
      gnt_id  = pick_id(sel_mask);
    end
    accept = gnt_vld && (mem2proc_response_i != '0);
    if (hold_live) begin
      if (accept) state_d = S_IDLE;
    end else if (state_q == S_HOLD) begin
      state_d = S_IDLE;
    end else if (gnt_vld && !accept) begin
      state_d   = S_HOLD;
      hold_id_d = gnt_id;
    end
  end

  // FSM state and latched grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      hold_id_q <= ID_IC;
    end else begin
      state_q   <= state_d;
      hold_id_q <= hold_id_d;
    end
  end

  // Bus drive from the current grant; data only carries store payload.
  always_comb begin
    cmd             = CMD_NONE;
    proc2mem_addr_o = '0;
    proc2mem_data_o = '0;
    if (gnt_vld) begin
      case (gnt_id)
        ID_DS: begin
          cmd             = CMD_STORE;
          proc2mem_addr_o = ds_addr_i;
          proc2mem_data_o = ds_data_i;
        end
        ID_DL: begin
          cmd             = CMD_LOAD;
          proc2mem_addr_o = dl_addr_i;
        end
        default: begin
          cmd             = CMD_LOAD;
          proc2mem_addr_o = ic_addr_i;
        end
      endcase
    end
  end

  assign proc2mem_cmd_o = cmd;
  assign ack[0]   = accept && (gnt_id == ID_IC);
  assign ack[1]   = accept && (gnt_id == ID_DL);
  assign ack[2]   = accept && (gnt_id == ID_DS);
  assign ic_ack_o = ack[0];
  assign dl_ack_o = ack[1];
  assign ds_ack_o = ack[2];
  assign arb_ld_full_o = ld_full;

  mem_tag_owner_tbl #(
    .TAG_W      (TAG_W),
    .MAX_LD_OUT (MAX_LD_OUT)
  ) u_owner_tbl (
    .clk         (clk),
    .rst         (rst),
    .alloc_i     (accept && (gnt_id != ID_DS)),
    .alloc_tag_i (mem2proc_response_i),
    .alloc_id_i  (gnt_id),
    .ret_tag_i   (mem2proc_tag_i),
    .ret_hit_o   (ret_hit),
    .ret_id_o    (ret_id),
    .ld_full_o   (ld_full)
  );

  assign ic_rsp_vld_o = ret_hit && (ret_id == ID_IC);
  assign dl_rsp_vld_o = ret_hit && (ret_id == ID_DL);
  assign rsp_tag_o    = ret_hit ? mem2proc_tag_i  : '0;
  assign rsp_data_o   = ret_hit ? mem2proc_data_i : '0;

endmodule
